// File: rtl/exe_w2_pkg.sv
// Shared types for the second-generation execution unit: opcodes, FSM states
// and status-word bit positions.
package exe_w2_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_INV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ST_ERR  = 3;
  localparam int unsigned ST_OVF  = 2;
  localparam int unsigned ST_NEG  = 1;
  localparam int unsigned ST_ZERO = 0;

endpackage

// File: rtl/exe_w2_muldiv.sv
// Iterative signed multiply/divide on operand magnitudes: one step per cycle for
// M cycles, with sign fix-up and overflow detection applied to the final step.
module exe_w2_muldiv #(
  parameter int unsigned M = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_is_div,
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  input  logic         i_busy,
  output logic         o_last,
  output logic [M-1:0] o_result,
  output logic         o_ovf
);

  localparam int unsigned CW = $clog2(M);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   hi_q, hi_d;
  logic [M-1:0]   lo_q, lo_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;
  logic [M:0]     rem_sh, trial, sum;
  logic [2*M-1:0] prod;
  logic [M-1:0]   quo;

  function automatic logic [M-1:0] mag(input logic [M-1:0] v);
    return v[M-1] ? -v : v;
  endfunction

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rem_sh   = '0;
    trial    = '0;
    sum      = '0;
    o_last   = i_busy && (cnt_q == CW'(M - 1));

    if (i_start) begin
      hi_d     = '0;
      lo_d     = mag(i_a);
      dvs_d    = mag(i_b);
      is_div_d = i_is_div;
      neg_d    = i_a[M-1] ^ i_b[M-1];
      cnt_d    = '0;
    end else if (i_busy) begin
      cnt_d = o_last ? '0 : cnt_q + 1'b1;
      if (is_div_q) begin
        // Restoring step: hi holds the remainder, lo shifts dividend out and quotient in.
        rem_sh = {hi_q, lo_q[M-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (!trial[M]) begin
          hi_d = trial[M-1:0];
          lo_d = {lo_q[M-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[M-1:0];
          lo_d = {lo_q[M-2:0], 1'b0};
        end
      end else begin
        sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        {hi_d, lo_d} = {sum, lo_q[M-1:1]};
      end
    end
  end

  // Fix-up reads the next-state values so the top can register the result on the last step.
  always_comb begin
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo  = neg_q ? -lo_d : lo_d;
    if (is_div_q) begin
      o_result = quo;
      o_ovf    = !neg_q && lo_d[M-1];
    end else begin
      o_result = prod[M-1:0];
      o_ovf    = prod[2*M-1:M-1] != {(M+1){prod[M-1]}};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/exe_unit_w2.sv
// Signed ALU with valid/ready handshake; single-cycle ops complete in one cycle,
// MUL and DIV are handed to the iterative multiply/divide unit.
module exe_unit_w2
  import exe_w2_pkg::*;
#(
  parameter int unsigned M = 8,
  parameter int unsigned N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_oper,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  output logic         o_valid,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  state_e       state_q, state_d;
  logic         rdy_q;
  logic [M-1:0] res_q, res_d;
  logic [3:0]   st_q, st_d;
  logic         vld_q, vld_d;

  logic         accept, hi_bad;
  op_e          op;
  logic [M-1:0] sum, diff, alu_res, md_res;
  logic         alu_err, alu_ovf, md_start, md_is_div, md_last, md_ovf;

  function automatic logic [3:0] status(input logic err, input logic ovf,
                                        input logic [M-1:0] res);
    logic [3:0] s;
    s          = '0;
    s[ST_ERR]  = err;
    s[ST_OVF]  = ovf;
    s[ST_NEG]  = res[M-1];
    s[ST_ZERO] = (res == '0);
    return s;
  endfunction

  // Ready is held low during reset and until the first clock edge after release.
  assign o_ready  = rdy_q && (state_q != BUSY);
  assign accept   = i_valid && o_ready;
  assign hi_bad   = (i_oper >> 3) != '0;
  assign op       = op_e'(i_oper[2:0]);
  assign sum      = i_argA + i_argB;
  assign diff     = i_argA - i_argB;
  assign o_valid  = vld_q;
  assign o_result = res_q;
  assign o_status = st_q;

  always_comb begin
    alu_res   = '0;
    alu_err   = 1'b0;
    alu_ovf   = 1'b0;
    md_start  = 1'b0;
    md_is_div = 1'b0;
    if (hi_bad) begin
      alu_err = 1'b1;
    end else begin
      case (op)
        OP_ADD: begin
          alu_res = sum;
          alu_ovf = (i_argA[M-1] == i_argB[M-1]) && (sum[M-1] != i_argA[M-1]);
        end
        OP_SUB: begin
          alu_res = diff;
          alu_ovf = (i_argA[M-1] != i_argB[M-1]) && (diff[M-1] != i_argA[M-1]);
        end
        OP_AND: alu_res = i_argA & i_argB;
        OP_OR:  alu_res = i_argA | i_argB;
        OP_SLT: alu_res = {{(M-1){1'b0}}, $signed(i_argA) < $signed(i_argB)};
        OP_MUL: md_start = accept;
        OP_DIV: begin
          if (i_argB == '0) begin
            alu_err = 1'b1;
          end else begin
            md_start  = accept;
            md_is_div = 1'b1;
          end
        end
        default: alu_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    st_d    = st_q;
    vld_d   = 1'b0;
    if (state_q == BUSY) begin
      if (md_last) begin
        state_d = DONE;
        res_d   = md_res;
        st_d    = status(1'b0, md_ovf, md_res);
        vld_d   = 1'b1;
      end
    end else begin
      state_d = IDLE;
      if (accept) begin
        if (md_start) begin
          state_d = BUSY;
        end else begin
          res_d = alu_res;
          st_d  = status(alu_err, alu_ovf, alu_res);
          vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      res_q   <= '0;
      st_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      res_q   <= res_d;
      st_q    <= st_d;
      vld_q   <= vld_d;
    end
  end

  exe_w2_muldiv #(.M(M)) u_muldiv (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (md_start),
    .i_is_div (md_is_div),
    .i_a      (i_argA),
    .i_b      (i_argB),
    .i_busy   (state_q == BUSY),
    .o_last   (md_last),
    .o_result (md_res),
    .o_ovf    (md_ovf)
  );

endmodule

// File: tb/tb_exe_unit_w2.sv
// Scoreboard bench for exe_unit_w2: the driver pushes reference results computed
// with integer arithmetic; a negedge monitor pops and compares on each o_valid.
module tb_exe_unit_w2;

  localparam int M = 8;
  localparam int N = 3;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic [N-1:0] i_oper = '0;
  logic [M-1:0] i_argA = '0;
  logic [M-1:0] i_argB = '0;
  logic         o_ready, o_valid;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;

  exe_unit_w2 #(.M(M), .N(N)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_oper   (i_oper),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_status (o_status)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [M-1:0] res;
    logic [3:0]   st;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           busy_end = 0;
  bit           mon_en = 1'b0;
  logic [M-1:0] last_res = '0;
  logic [3:0]   last_st = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int op, input logic [M-1:0] a, input logic [M-1:0] b);
    exp_t        e;
    int          sa, sb2, r, lo, hi;
    bit          err, ovf;
    logic [31:0] rr;
    sa  = int'($signed(a));
    sb2 = int'($signed(b));
    lo  = -(1 << (M - 1));
    hi  = (1 << (M - 1)) - 1;
    err = 1'b0;
    ovf = 1'b0;
    r   = 0;
    case (op)
      0: begin r = sa + sb2; ovf = (r < lo) || (r > hi); end
      1: begin r = sa - sb2; ovf = (r < lo) || (r > hi); end
      2: r = int'(a & b);
      3: r = int'(a | b);
      4: r = (sa < sb2) ? 1 : 0;
      5: begin r = sa * sb2; ovf = (r < lo) || (r > hi); end
      6: begin
        if (sb2 == 0) err = 1'b1;
        else begin r = sa / sb2; ovf = (r > hi); end
      end
      default: err = 1'b1;
    endcase
    rr    = r;
    e.res = rr[M-1:0];
    e.st  = {err, ovf, e.res[M-1], e.res == '0};
    e.due = 0;
    return e;
  endfunction

  // Monitor: compares every cycle against the scoreboard and the expected ready window.
  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      exp_t e;
      check("o_ready", o_ready, cyc >= busy_end);
      if (o_valid) begin
        if (sb.size() == 0) begin
          check("spurious_o_valid", o_valid, 0);
        end else begin
          e = sb.pop_front();
          check("result", o_result, e.res);
          check("status", o_status, e.st);
          check("latency_cycle", cyc, e.due);
          last_res = e.res;
          last_st  = e.st;
        end
      end else begin
        check("hold_result", o_result, last_res);
        check("hold_status", o_status, last_st);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          check("missing_o_valid", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called at negedge+1; while the DUT is busy it holds i_valid high with junk operands.
  task automatic issue(input int op, input logic [M-1:0] a, input logic [M-1:0] b, input int gap);
    exp_t e;
    int   waited;
    int   t;
    bit   long_op;
    waited  = 0;
    i_valid = 1'b1;
    while (!o_ready) begin
      i_oper = N'($urandom_range(0, 7));
      i_argA = M'($urandom);
      i_argB = M'($urandom);
      @(negedge i_clk); #1;
      waited++;
      if (waited > 100) begin
        check("ready_timeout", o_ready, 1);
        i_valid = 1'b0;
        return;
      end
    end
    i_oper  = N'(op);
    i_argA  = a;
    i_argB  = b;
    e       = model(op, a, b);
    t       = cyc + 1;
    long_op = (op == 5) || (op == 6 && b != '0);
    e.due   = long_op ? t + M : t;
    if (long_op) busy_end = t + M;
    sb.push_back(e);
    @(negedge i_clk); #1;
    i_valid = 1'b0;
    repeat (gap) begin
      @(negedge i_clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic logic [M-1:0] rnd_arg();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      3: return 8'h00;
      4: return 8'h01;
      default: return M'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           op;
    logic [M-1:0] a, b;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_result", o_result, 0);
    check("rst_status", o_status, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("ready_before_first_edge", o_ready, 0);
    @(negedge i_clk); #1;
    check("ready_after_release", o_ready, 1);
    busy_end = 0;
    mon_en   = 1'b1;

    issue(0, 8'h7F, 8'h01, 0);
    issue(1, 8'h05, 8'h05, 0);
    issue(2, 8'hF0, 8'h0F, 2);
    issue(5, 8'hFD, 8'h07, 0);
    issue(5, 8'h10, 8'h10, 0);
    issue(5, 8'h80, 8'h01, 0);
    issue(6, 8'hF9, 8'h02, 0);
    issue(6, 8'h80, 8'hFF, 0);
    issue(6, 8'h09, 8'h00, 0);
    issue(7, 8'h12, 8'h34, 1);
    issue(4, 8'h80, 8'h7F, 0);
    drain();

    // Reset in the middle of a multiply: no result may ever appear.
    issue(5, 8'h07, 8'h09, 0);
    repeat (3) @(negedge i_clk);
    #2;
    mon_en = 1'b0;
    i_rst  = 1'b1;
    #1;
    check("abort_valid", o_valid, 0);
    check("abort_result", o_result, 0);
    check("abort_status", o_status, 0);
    check("abort_ready", o_ready, 0);
    sb.delete();
    busy_end = 0;
    last_res = '0;
    last_st  = '0;
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    check("abort_ready_released", o_ready, 0);
    @(negedge i_clk); #1;
    check("abort_ready_edge", o_ready, 1);
    mon_en = 1'b1;
    repeat (12) begin
      @(negedge i_clk); #1;
    end
    issue(0, 8'h02, 8'h03, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7);
      a  = rnd_arg();
      b  = rnd_arg();
      issue(op, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    drain();
    repeat (3) begin
      @(negedge i_clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
